// File: rtl/switch_mailbox_pkg.sv
// Shared types and helpers for the buffered core<->switch mailbox.
// Payload elements are carried as raw IEEE-754 single-precision bit patterns.
package switch_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_CORE_SIZE = 8;
  localparam int ELEM_BITS     = 32;
  localparam int MAX_CELLS     = 1024;

  typedef logic [ELEM_BITS-1:0]             elem_t;
  typedef elem_t [DEF_WIDTH-1:0]            switch_word_t;
  typedef logic [$clog2(DEF_CORE_SIZE)-1:0] core_idx_t;

  // Per-core handshake side: the ACK state is the one-cycle ok/ready pulse.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  function automatic int unsigned popcount(input logic [MAX_CELLS-1:0] cells);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CELLS; i++) begin
      n += 32'(cells[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/switch_mailbox_slot.sv
// One mailbox cell: a single payload register with a full flag.
// Exactly one writer and one reader; accept logic never asserts both in one cycle.
module mailbox_slot
  import switch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  elem_t [WIDTH-1:0]      wr_data,
  input  logic                   rd_en,
  output logic                   full,
  output elem_t [WIDTH-1:0]      data
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

  // Payload is don't-care after reset, so it carries no reset term.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data <= wr_data;
    end
  end

endmodule

// File: rtl/switch_mailbox.sv
// Buffered responder for the core<->switch send/recv protocol: one slot per
// (destination, source) pair, so senders complete without meeting their receiver.
//
// Handshake: a core raises send_ready (or recv_request) and holds it until the
// matching one-cycle send_ok (recv_ready) pulse; acceptance uses pre-edge state and
// the pulse cycle itself never accepts, so a held request is taken only once.
module switch_mailbox
  import switch_pkg::*;
#(
  parameter  int WIDTH          = DEF_WIDTH,
  parameter  int CORE_SIZE      = DEF_CORE_SIZE,
  localparam int CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic  [CORE_SIZE-1:0]                      send_ready,
  input  logic  [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]  send_core_idx,
  input  elem_t [CORE_SIZE-1:0][WIDTH-1:0]           send_data,
  output logic  [CORE_SIZE-1:0]                      send_ok,
  input  logic  [CORE_SIZE-1:0]                      recv_request,
  input  logic  [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]  recv_core_idx,
  output logic  [CORE_SIZE-1:0]                      recv_ready,
  output elem_t [CORE_SIZE-1:0][WIDTH-1:0]           recv_data,
  output logic  [CORE_ADDR_SIZE*2:0]                 slots_used
);

  localparam int SW = CORE_ADDR_SIZE * 2 + 1;

  // Matrices are indexed [dst][src].
  logic  [CORE_SIZE-1:0][CORE_SIZE-1:0]            full;
  logic  [CORE_SIZE-1:0][CORE_SIZE-1:0]            full_next;
  logic  [CORE_SIZE-1:0][CORE_SIZE-1:0]            wr_en;
  logic  [CORE_SIZE-1:0][CORE_SIZE-1:0]            rd_en;
  elem_t [CORE_SIZE-1:0][CORE_SIZE-1:0][WIDTH-1:0] slot_data;

  logic [CORE_SIZE-1:0] send_acc;
  logic [CORE_SIZE-1:0] recv_acc;
  logic [CORE_SIZE-1:0] send_state;
  logic [CORE_SIZE-1:0] recv_state;

  always_comb begin
    send_acc  = '0;
    recv_acc  = '0;
    wr_en     = '0;
    rd_en     = '0;
    for (int c = 0; c < CORE_SIZE; c++) begin
      send_acc[c] = send_ready[c] && (send_state[c] == ST_IDLE) &&
                    !full[send_core_idx[c]][c];
      recv_acc[c] = recv_request[c] && (recv_state[c] == ST_IDLE) &&
                    full[c][recv_core_idx[c]];
    end
    for (int dst = 0; dst < CORE_SIZE; dst++) begin
      for (int src = 0; src < CORE_SIZE; src++) begin
        wr_en[dst][src] = send_acc[src] &&
                          (send_core_idx[src] == CORE_ADDR_SIZE'(dst));
        rd_en[dst][src] = recv_acc[dst] &&
                          (recv_core_idx[dst] == CORE_ADDR_SIZE'(src));
      end
    end
    // A read needs full and a write needs empty, so they never hit one slot together.
    full_next = (full & ~rd_en) | wr_en;
  end

  for (genvar gd = 0; gd < CORE_SIZE; gd++) begin : g_dst
    for (genvar gs = 0; gs < CORE_SIZE; gs++) begin : g_src
      mailbox_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en[gd][gs]),
        .wr_data (send_data[gs]),
        .rd_en   (rd_en[gd][gs]),
        .full    (full[gd][gs]),
        .data    (slot_data[gd][gs])
      );
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      send_state <= '0;
      recv_state <= '0;
      recv_data  <= '0;
      slots_used <= '0;
    end else begin
      for (int c = 0; c < CORE_SIZE; c++) begin
        send_state[c] <= send_acc[c] ? ST_ACK : ST_IDLE;
        recv_state[c] <= recv_acc[c] ? ST_ACK : ST_IDLE;
        if (recv_acc[c]) begin
          recv_data[c] <= slot_data[c][recv_core_idx[c]];
        end
      end
      slots_used <= SW'(popcount(MAX_CELLS'(full_next)));
    end
  end

  assign send_ok    = send_state;
  assign recv_ready = recv_state;

endmodule

// File: tb/tb_switch_mailbox.sv
// Directed bench for switch_mailbox: stimulus pushes expected receives into a
// queue and a negedge monitor pops and compares on every recv_ready pulse.
module tb_switch_mailbox;
  import switch_pkg::*;

  localparam int W  = 16;
  localparam int CS = 8;
  localparam int AW = 3;
  localparam int EW = AW + W * 32;

  logic                           clock = 1'b0;
  logic                           reset = 1'b0;
  logic [CS-1:0]                  send_ready = '0;
  logic [CS-1:0][AW-1:0]          send_core_idx = '0;
  switch_word_t [CS-1:0]          send_data = '0;
  logic [CS-1:0]                  send_ok;
  logic [CS-1:0]                  recv_request = '0;
  logic [CS-1:0][AW-1:0]          recv_core_idx = '0;
  logic [CS-1:0]                  recv_ready;
  switch_word_t [CS-1:0]          recv_data;
  logic [2*AW:0]                  slots_used;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int checks = 0;
  int errors = 0;
  int lat;

  // Single-precision bit patterns for 0.0 .. 7.0
  logic [31:0] int_f [CS] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000,
                              32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
                              32'h40C0_0000, 32'h40E0_0000};

  switch_mailbox #(.WIDTH(W), .CORE_SIZE(CS)) dut (
    .clock         (clock),
    .reset         (reset),
    .send_ready    (send_ready),
    .send_core_idx (send_core_idx),
    .send_data     (send_data),
    .send_ok       (send_ok),
    .recv_request  (recv_request),
    .recv_core_idx (recv_core_idx),
    .recv_ready    (recv_ready),
    .recv_data     (recv_data),
    .slots_used    (slots_used)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic switch_word_t fill(input logic [31:0] v);
    switch_word_t w;
    for (int i = 0; i < W; i++) w[i] = v;
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_send(input int c, input int d, input logic [31:0] v, output int l);
    send_ready[c]    = 1'b1;
    send_core_idx[c] = AW'(d);
    send_data[c]     = fill(v);
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (send_ok[c]) begin
        l = i;
        break;
      end
    end
    send_ready[c] = 1'b0;
  endtask

  task automatic do_recv(input int d, input int s, input logic [31:0] v, output int l);
    exp_q.push_back({AW'(d), fill(v)});
    recv_request[d]  = 1'b1;
    recv_core_idx[d] = AW'(s);
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (recv_ready[d]) begin
        l = i;
        break;
      end
    end
    recv_request[d] = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    for (int d = 0; d < CS; d++) begin
      if (recv_ready[d]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL recv_unexpected: core %0d pulsed recv_ready with no expected entry", d);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e !== {AW'(d), recv_data[d]}) begin
            errors++;
            $display("FAIL recv_data: got core %0d data %h expected core %0d data %h",
                     d, recv_data[d], mon_e[EW-1 -: AW], mon_e[EW-AW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    // reset held with every core requesting a self-send
    for (int c = 0; c < CS; c++) begin
      send_core_idx[c] = AW'(c);
      send_data[c]     = fill(int_f[1]);
    end
    send_ready = '1;
    tick();
    tick();
    chk("reset_send_ok", 64'(send_ok), 64'h0);
    chk("reset_recv_ready", 64'(recv_ready), 64'h0);
    chk("reset_slots_used", 64'(slots_used), 64'h0);
    chk("reset_recv_data", 64'(|recv_data), 64'h0);
    reset = 1'b1;
    tick();
    chk("first_accept_send_ok", 64'(send_ok), 64'hFF);
    chk("first_accept_slots", 64'(slots_used), 64'd8);
    tick();
    chk("held_send_ok_cooldown", 64'(send_ok), 64'h0);
    send_ready = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("cleared_slots", 64'(slots_used), 64'h0);

    // basic transfer
    do_send(0, 4, 32'h3FC0_0000, lat);
    chk("basic_send_latency", 64'(lat), 64'd1);
    chk("basic_slots_one", 64'(slots_used), 64'd1);
    do_recv(4, 0, 32'h3FC0_0000, lat);
    chk("basic_recv_latency", 64'(lat), 64'd1);
    chk("basic_slots_zero", 64'(slots_used), 64'd0);
    tick();
    chk("recv_data_holds", 64'(recv_data[4][0]), 64'h3FC0_0000);

    // backpressure
    do_send(1, 5, 32'h4000_0000, lat);
    chk("bp_first_send_latency", 64'(lat), 64'd1);
    send_ready[1]    = 1'b1;
    send_core_idx[1] = 3'd5;
    send_data[1]     = fill(32'h4040_0000);
    repeat (3) tick();
    chk("bp_second_send_stalled", 64'(send_ok[1]), 64'h0);
    exp_q.push_back({3'd5, fill(32'h4000_0000)});
    recv_request[5]  = 1'b1;
    recv_core_idx[5] = 3'd1;
    tick();
    chk("bp_recv_ready", 64'(recv_ready[5]), 64'h1);
    chk("bp_send_still_stalled", 64'(send_ok[1]), 64'h0);
    recv_request[5] = 1'b0;
    tick();
    chk("bp_send_ok_after_drain", 64'(send_ok[1]), 64'h1);
    chk("bp_slots_refilled", 64'(slots_used), 64'd1);
    send_ready[1] = 1'b0;
    do_recv(5, 1, 32'h4040_0000, lat);
    chk("bp_second_recv_latency", 64'(lat), 64'd1);

    // same-cycle collision on slot[6][2]
    do_send(2, 6, 32'h4080_0000, lat);
    chk("col_fill_latency", 64'(lat), 64'd1);
    send_ready[2]    = 1'b1;
    send_core_idx[2] = 3'd6;
    send_data[2]     = fill(32'h40A0_0000);
    exp_q.push_back({3'd6, fill(32'h4080_0000)});
    recv_request[6]  = 1'b1;
    recv_core_idx[6] = 3'd2;
    tick();
    chk("col_recv_ready", 64'(recv_ready[6]), 64'h1);
    chk("col_send_deferred", 64'(send_ok[2]), 64'h0);
    recv_request[6] = 1'b0;
    tick();
    chk("col_send_ok_late", 64'(send_ok[2]), 64'h1);
    send_ready[2] = 1'b0;
    do_recv(6, 2, 32'h40A0_0000, lat);
    chk("col_second_recv_latency", 64'(lat), 64'd1);
    chk("col_slots_zero", 64'(slots_used), 64'd0);

    // all-to-all ring
    for (int c = 0; c < CS; c++) begin
      send_core_idx[c] = AW'((c + 1) % CS);
      send_data[c]     = fill(int_f[c]);
    end
    send_ready = '1;
    tick();
    chk("ring_send_ok_all", 64'(send_ok), 64'hFF);
    chk("ring_slots_eight", 64'(slots_used), 64'd8);
    send_ready = '0;
    tick();
    for (int d = 0; d < CS; d++) begin
      recv_core_idx[d] = AW'((d + CS - 1) % CS);
      exp_q.push_back({AW'(d), fill(int_f[(d + CS - 1) % CS])});
    end
    recv_request = '1;
    tick();
    chk("ring_recv_ready_all", 64'(recv_ready), 64'hFF);
    chk("ring_slots_zero", 64'(slots_used), 64'd0);
    recv_request = '0;
    tick();

    // held request writes once, then reset with three slots full
    send_ready[3]    = 1'b1;
    send_core_idx[3] = 3'd3;
    send_data[3]     = fill(int_f[1]);
    tick();
    chk("held_ok_pulse", 64'(send_ok[3]), 64'h1);
    tick();
    chk("held_ok_drop", 64'(send_ok[3]), 64'h0);
    tick();
    chk("held_single_write", 64'(slots_used), 64'd1);
    send_ready[3] = 1'b0;
    do_send(0, 1, int_f[2], lat);
    do_send(1, 2, int_f[3], lat);
    chk("three_slots_full", 64'(slots_used), 64'd3);
    reset = 1'b0;
    tick();
    chk("midreset_slots", 64'(slots_used), 64'd0);
    reset = 1'b1;
    recv_request[3]  = 1'b1;
    recv_core_idx[3] = 3'd3;
    repeat (4) tick();
    chk("midreset_recv_stalls", 64'(recv_ready[3]), 64'h0);
    recv_request[3] = 1'b0;
    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_mailbox.md
Name: switch_mailbox

Overview:
- Buffered responder end of the core↔switch send/recv protocol.
- Drop-in alternative to the crossbar Switch in multi-core processor tops: same port shapes, same core-side handshake.
- Holds one mailbox slot per (destination, source) pair, so a sender completes without a rendezvous with its receiver.
- Decouples MatCore/VecCore send and recv timing; used for tops where producers run ahead of consumers.

Parameters:
- WIDTH, 16, shortreal elements per transfer.
- CORE_SIZE, 8, number of attached cores.
- CORE_ADDR_SIZE, $clog2(CORE_SIZE), core index width (derived; do not override).

Ports:
- clock  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-low; sampled on posedge clock.
- send_ready  input  [CORE_SIZE]  core c requests a send; held high until its send_ok.
- send_core_idx  input  [CORE_SIZE][CORE_ADDR_SIZE]  destination core of core c's send.
- send_data  input  [CORE_SIZE][WIDTH] shortreal  payload from core c.
- send_ok  output  [CORE_SIZE]  one-cycle pulse: core c's send was accepted.
- recv_request  input  [CORE_SIZE]  core d requests a receive; held high until its recv_ready.
- recv_core_idx  input  [CORE_SIZE][CORE_ADDR_SIZE]  source core core d wants data from.
- recv_ready  output  [CORE_SIZE]  one-cycle pulse: recv_data[d] is valid.
- recv_data  output  [CORE_SIZE][WIDTH] shortreal  payload to core d; holds its last value otherwise.
- slots_used  output  CORE_ADDR_SIZE*2+1  number of full slots, registered.

Behaviour:
Storage
- Slot array slot[dst][src]: WIDTH shortreals plus a full bit.
- Each slot has exactly one writer (src) and one reader (dst), so no arbitration is needed.

Reset
- When reset==0 at a posedge, all full bits, send_ok, recv_ready and slots_used go to 0, and recv_data goes to 0.0.
- Slot payload contents are don't-care.
- Reset asserted mid-transfer discards all buffered data; no send_ok or recv_ready is emitted on that cycle.

Send (per core c, d = send_core_idx[c])
- Accept condition: send_ready[c] && !send_ok[c] && !slot[d][c].full, using pre-edge state.
- On accept:
  - slot[d][c] takes send_data[c] and full=1.
  - send_ok[c]=1 on the next cycle only, for a latency of 1.
- The send_ok-high cooldown stops a core that still holds send_ready during its ok cycle from writing twice.
- A full slot stalls the sender; send_ok stays 0 with no limit on duration.

Recv (per core d, s = recv_core_idx[d])
- Accept condition: recv_request[d] && !recv_ready[d] && slot[d][s].full, using pre-edge state.
- On accept:
  - recv_data[d] takes slot[d][s] and full is cleared.
  - recv_ready[d]=1 on the next cycle only.
- An empty slot stalls the receiver.

Simultaneous events
- Read and write to the same slot in one cycle both use pre-edge state:
  - full slot: the read drains it and the write stalls one cycle.
  - empty slot: the write fills it and the read stalls one cycle.
  - Net: the slot never holds two values and never loses data.
- Self-send (d==c) is legal and uses slot[c][c].
- All CORE_SIZE cores may send and receive in the same cycle.

Slot count and stability
- slots_used = registered popcount of full bits, updated the same edge as the slots. Range 0..CORE_SIZE², with no wrap.
- Changing send_core_idx or send_data while waiting is allowed; the value sampled on the accept edge is the one used.

State per core side
- Two states: IDLE/WAIT (request pending, condition false) and ACK (pulse cycle).
- Transition ACK→IDLE is unconditional.

Decomposition:
- Package switch_pkg:
  - switch_word_t (shortreal [WIDTH] payload).
  - core_idx_t.
  - a function popcount over the full matrix.
- Natural sub-module mailbox_slot:
  - Inputs: write-enable, data, read-enable.
  - Outputs: full, data.
  - Instantiated CORE_SIZE² times in a generate loop.
- Top level holds only the accept logic and the output registers.

Test Plan:
- Reset: hold reset=0 for 2 cycles with send_ready all 1 → send_ok, recv_ready and slots_used all 0; after release, the first accepts appear with 1-cycle latency.
- Basic transfer:
  - core0 sends 16×1.5 to core4 → send_ok[0] pulses at T+1 and slots_used=1.
  - core4 then requests from src 0 → recv_ready[4] pulses one cycle with recv_data[4]=all 1.5, and slots_used=0.
- Backpressure:
  - core1 sends 2.0 to core5 and then sends 3.0 to core5 with no recv in between → the second send_ok is withheld.
  - core5 recv → gets 2.0; the next send_ok[1] comes 1 cycle later; a second recv gets 3.0.
- Same-cycle collision:
  - With slot[6][2] full (4.0), core2 sends 5.0 and core6 receives in the same cycle → recv gets 4.0 and the send is accepted one cycle later.
  - A following recv gets 5.0.
- All-to-all: each core c sends the value c to core (c+1)%8 simultaneously → 8 send_ok pulses in one cycle, slots_used=8; all receives return the correct c.
- Held request plus mid-operation reset:
  - A core holding send_ready across its ok cycle writes only once (slots_used=1).
  - Reset asserted while 3 slots are full → slots_used=0 and receives stall.
